// File: rtl/fetch_stage.sv
// IF stage: owns the PC, drives the imem request port and the IF/ID register.
// Ports: clock/reset_n, hazard stall (PCWrite, IFIDWrite), branch redirect
// (BranchAddr, brunch_taken, brunch_control), imem req/addr/ready/rdata,
// IF/ID outputs (IDinst, IDpc_plus_4), fetch_busy while not in FETCH.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        PCWrite,
    input  logic        IFIDWrite,
    input  logic [31:0] BranchAddr,
    input  logic        brunch_taken,
    input  logic        brunch_control,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IDinst,
    output logic [31:0] IDpc_plus_4,
    output logic        fetch_busy
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic [31:0] pc;
    logic [31:0] pc_nx;
    logic [31:0] pc_inc;
    logic [31:0] inst_nx;
    logic [31:0] pc4_nx;
    logic [31:0] buf_q;
    logic [31:0] buf_nx;
    logic [31:0] tgt_q;
    logic [31:0] tgt_nx;
    logic        redirect;
    logic        advance;

    assign redirect  = brunch_control & brunch_taken;
    assign advance   = PCWrite & IFIDWrite;
    assign pc_inc    = pc + 32'd4;
    assign imem_addr = pc;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= FETCH;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            FETCH: begin
                if (imem_ready) begin
                    if (!redirect && !advance) begin
                        state_nx = HOLD;
                    end
                end else if (redirect) begin
                    state_nx = DRAIN;
                end
            end
            HOLD: begin
                if (redirect || advance) begin
                    state_nx = FETCH;
                end
            end
            DRAIN: begin
                if (imem_ready) begin
                    state_nx = FETCH;
                end
            end
            default: state_nx = FETCH;
        endcase
    end

    always_comb begin
        imem_req   = reset_n && (state != HOLD);
        fetch_busy = (state != FETCH);
    end

    // PC is frozen in HOLD, so the buffered instruction's PC+4 is
    // simply pc_inc when it is finally released; only rdata is kept.
    always_comb begin
        pc_nx   = pc;
        inst_nx = IDinst;
        pc4_nx  = IDpc_plus_4;
        buf_nx  = buf_q;
        tgt_nx  = tgt_q;
        unique case (state)
            FETCH: begin
                if (imem_ready) begin
                    if (redirect) begin
                        pc_nx   = BranchAddr;
                        inst_nx = NOP_INST;
                    end else if (advance) begin
                        inst_nx = imem_rdata;
                        pc4_nx  = pc_inc;
                        pc_nx   = pc_inc;
                    end else begin
                        buf_nx  = imem_rdata;
                    end
                end else if (redirect) begin
                    // Address must stay put until the
                    // in-flight fetch completes.
                    tgt_nx  = BranchAddr;
                    inst_nx = NOP_INST;
                end else if (IFIDWrite) begin
                    inst_nx = NOP_INST;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_nx   = BranchAddr;
                    inst_nx = NOP_INST;
                end else if (advance) begin
                    inst_nx = buf_q;
                    pc4_nx  = pc_inc;
                    pc_nx   = pc_inc;
                end
            end
            DRAIN: begin
                if (redirect || IFIDWrite) begin
                    inst_nx = NOP_INST;
                end
                if (redirect) begin
                    tgt_nx = BranchAddr;
                end
                if (imem_ready) begin
                    pc_nx = redirect ? BranchAddr : tgt_q;
                end
            end
            default: begin
                pc_nx = pc;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            IDinst      <= NOP_INST;
            IDpc_plus_4 <= 32'd0;
            buf_q       <= 32'd0;
            tgt_q       <= 32'd0;
        end else begin
            pc          <= pc_nx;
            IDinst      <= inst_nx;
            IDpc_plus_4 <= pc4_nx;
            buf_q       <= buf_nx;
            tgt_q       <= tgt_nx;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations,
// then randomized stalls/redirects/imem latency against a reference model.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        PCWrite;
    logic        IFIDWrite;
    logic [31:0] BranchAddr;
    logic        brunch_taken;
    logic        brunch_control;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] IDinst;
    logic [31:0] IDpc_plus_4;
    logic        fetch_busy;

    int passed = 0;
    int total  = 0;

    // Reference model: architectural view of the fetch unit.
    logic [31:0] m_pc   = 32'd0;
    logic [31:0] m_inst = 32'd0;
    logic [31:0] m_pc4  = 32'd0;
    logic [31:0] m_buf  = 32'd0;
    logic [31:0] m_tgt  = 32'd0;
    bit          m_hold = 1'b0;
    bit          m_drain = 1'b0;

    fetch_stage #(
        .RESET_PC(RST_PC),
        .NOP_INST(NOP)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .PCWrite       (PCWrite),
        .IFIDWrite     (IFIDWrite),
        .BranchAddr    (BranchAddr),
        .brunch_taken  (brunch_taken),
        .brunch_control(brunch_control),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .IDinst        (IDinst),
        .IDpc_plus_4   (IDpc_plus_4),
        .fetch_busy    (fetch_busy)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B9) + 32'h1234_5679;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit pw, input bit iw,
                              input bit redir, input logic [31:0] ba,
                              input bit rdy);
        bit adv;
        adv = pw & iw;
        if (!r) begin
            m_pc    = RST_PC;
            m_inst  = NOP;
            m_pc4   = 32'd0;
            m_hold  = 1'b0;
            m_drain = 1'b0;
        end else if (m_hold) begin
            if (redir) begin
                m_hold = 1'b0;
                m_pc   = ba;
                m_inst = NOP;
            end else if (adv) begin
                m_hold = 1'b0;
                m_inst = m_buf;
                m_pc4  = m_pc + 32'd4;
                m_pc   = m_pc + 32'd4;
            end
        end else if (m_drain) begin
            if (redir) m_tgt = ba;
            if (redir || iw) m_inst = NOP;
            if (rdy) begin
                m_drain = 1'b0;
                m_pc    = m_tgt;
            end
        end else if (rdy) begin
            if (redir) begin
                m_pc   = ba;
                m_inst = NOP;
            end else if (adv) begin
                m_inst = mem(m_pc);
                m_pc4  = m_pc + 32'd4;
                m_pc   = m_pc + 32'd4;
            end else begin
                m_buf  = mem(m_pc);
                m_hold = 1'b1;
            end
        end else if (redir) begin
            m_tgt   = ba;
            m_drain = 1'b1;
            m_inst  = NOP;
        end else if (iw) begin
            m_inst = NOP;
        end
    endtask

    task automatic compare_all();
        chk("imem_req", {31'd0, imem_req},
            {31'd0, reset_n & ~m_hold});
        chk("imem_addr", imem_addr, m_pc);
        chk("IDinst", IDinst, m_inst);
        chk("IDpc_plus_4", IDpc_plus_4, m_pc4);
        chk("fetch_busy", {31'd0, fetch_busy},
            {31'd0, m_hold | m_drain});
    endtask

    // Called at a falling edge: drive inputs, step model, check after edge.
    task automatic tick(input bit r, input bit pw, input bit iw,
                        input bit bc, input bit bt,
                        input logic [31:0] ba, input bit rdy);
        reset_n        = r;
        PCWrite        = pw;
        IFIDWrite      = iw;
        brunch_control = bc;
        brunch_taken   = bt;
        BranchAddr     = ba;
        imem_ready     = rdy;
        imem_rdata     = mem(imem_addr);
        model_step(r, pw, iw, bc & bt, ba, rdy);
        @(posedge clock);
        @(negedge clock);
        compare_all();
    endtask

    task automatic adv_t(input bit rdy);
        tick(1, 1, 1, 0, 0, 32'd0, rdy);
    endtask

    task automatic br_t(input logic [31:0] ba, input bit rdy);
        tick(1, 1, 1, 1, 1, ba, rdy);
    endtask

    initial begin
        bit r;
        bit pw;
        bit iw;
        bit bc;
        bit bt;
        bit rdy;
        logic [31:0] ba;

        // Reset
        tick(0, 0, 0, 0, 0, 32'd0, 0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_inst", IDinst, NOP);
        chk("rst_pc4", IDpc_plus_4, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);

        // Straight-line fetch
        adv_t(1);
        chk("sl_inst0", IDinst, mem(32'h0));
        chk("sl_pc4_0", IDpc_plus_4, 32'd4);
        adv_t(1);
        chk("sl_inst1", IDinst, mem(32'h4));
        chk("sl_pc4_1", IDpc_plus_4, 32'd8);

        // Stall at PC=8 for two cycles
        tick(1, 0, 0, 0, 0, 32'd0, 1);
        tick(1, 0, 0, 0, 0, 32'd0, 0);
        chk("st_busy", {31'd0, fetch_busy}, 32'd1);
        chk("st_req", {31'd0, imem_req}, 32'd0);
        chk("st_addr", imem_addr, 32'd8);
        chk("st_inst", IDinst, mem(32'h4));
        adv_t(0);
        chk("st_rel_inst", IDinst, mem(32'h8));
        chk("st_rel_pc4", IDpc_plus_4, 32'd12);

        // Taken branch: one bubble
        br_t(32'h40, 1);
        chk("br_bubble", IDinst, NOP);
        chk("br_addr", imem_addr, 32'h40);
        adv_t(1);
        chk("br_inst", IDinst, mem(32'h40));
        chk("br_pc4", IDpc_plus_4, 32'h44);

        // Slow imem with redirect in first wait cycle
        br_t(32'h80, 0);
        chk("dr_addr0", imem_addr, 32'h44);
        chk("dr_busy", {31'd0, fetch_busy}, 32'd1);
        adv_t(0);
        adv_t(0);
        chk("dr_addr2", imem_addr, 32'h44);
        adv_t(1);
        chk("dr_addr3", imem_addr, 32'h80);
        chk("dr_inst3", IDinst, NOP);
        adv_t(1);
        chk("dr_inst4", IDinst, mem(32'h80));
        chk("dr_pc4", IDpc_plus_4, 32'h84);

        // Redirect while holding a buffered instruction
        tick(1, 0, 0, 0, 0, 32'd0, 1);
        tick(1, 0, 0, 1, 1, 32'h100, 0);
        chk("hr_inst", IDinst, NOP);
        chk("hr_addr", imem_addr, 32'h100);
        adv_t(1);
        chk("hr_inst2", IDinst, mem(32'h100));

        // Reset in the middle of a drain
        br_t(32'h200, 0);
        tick(0, 1, 1, 0, 0, 32'd0, 1);
        chk("rd_req", {31'd0, imem_req}, 32'd0);
        chk("rd_inst", IDinst, NOP);
        chk("rd_pc4", IDpc_plus_4, 32'd0);
        chk("rd_addr", imem_addr, RST_PC);
        adv_t(1);
        chk("rd_inst2", IDinst, mem(32'h0));

        // PC wrap and unaligned address pass-through
        br_t(32'hFFFF_FFFC, 1);
        adv_t(1);
        chk("wr_pc4", IDpc_plus_4, 32'd0);
        chk("wr_addr", imem_addr, 32'd0);
        br_t(32'h0000_0102, 1);
        chk("ua_addr", imem_addr, 32'h102);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 59) != 0);
            pw  = ($urandom_range(0, 3) != 0);
            iw  = ($urandom_range(0, 3) != 0);
            bc  = ($urandom_range(0, 4) == 0);
            bt  = ($urandom_range(0, 1) == 0);
            rdy = imem_req && ($urandom_range(0, 2) != 0);
            ba  = {$urandom_range(0, 16'hFFFF), 16'h0};
            ba  = $urandom_range(0, 3) == 0 ? $urandom() : ba >> 12;
            tick(r, pw, iw, bc, bt, ba, rdy);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
